// File: rtl/int_issue_queue_if.sv
// Integer issue queue bus: dispatch packet, CDB broadcast, flush and issue handshake.
// The queue takes the slave side; the dispatcher/execute/testbench side is master.
interface int_issue_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          dispatch_en;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic          rs1_data_valid;
    logic          rs2_data_valid;
    logic [5:0]    rs1_tag;
    logic [5:0]    rs2_tag;
    logic [5:0]    rd_tag;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic [6:0]    func7;
    logic          cdb_valid;
    logic [5:0]    cdb_tag;
    logic [31:0]   cdb_data;
    logic          flush;
    logic          issue_ready;
    logic          issue_valid;
    logic [31:0]   issue_rs1_data;
    logic [31:0]   issue_rs2_data;
    logic [5:0]    issue_rd_tag;
    logic [6:0]    issue_opcode;
    logic [2:0]    issue_func3;
    logic [6:0]    issue_func7;
    logic          queue_full;
    logic [CW-1:0] entry_count;

    modport slave (
        input  dispatch_en, rs1_data, rs2_data,
        input  rs1_data_valid, rs2_data_valid,
        input  rs1_tag, rs2_tag, rd_tag,
        input  opcode, func3, func7,
        input  cdb_valid, cdb_tag, cdb_data,
        input  flush, issue_ready,
        output issue_valid, issue_rs1_data, issue_rs2_data,
        output issue_rd_tag, issue_opcode, issue_func3, issue_func7,
        output queue_full, entry_count
    );

    modport master (
        output dispatch_en, rs1_data, rs2_data,
        output rs1_data_valid, rs2_data_valid,
        output rs1_tag, rs2_tag, rd_tag,
        output opcode, func3, func7,
        output cdb_valid, cdb_tag, cdb_data,
        output flush, issue_ready,
        input  issue_valid, issue_rs1_data, issue_rs2_data,
        input  issue_rd_tag, issue_opcode, issue_func3, issue_func7,
        input  queue_full, entry_count
    );
endinterface

// File: rtl/int_issue_queue.sv
// Integer reservation station: shift-compacting array, oldest-ready-first issue,
// CDB wakeup of stored and incoming operands, flush and async reset.
module int_issue_queue #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    int_issue_queue_if.slave io_iq
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic        v;
        logic        a_v;
        logic [5:0]  a_t;
        logic [31:0] a_d;
        logic        b_v;
        logic [5:0]  b_t;
        logic [31:0] b_d;
        logic [5:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } ent_t;

    ent_t          r_q [DEPTH];
    logic [CW-1:0] r_cnt;

    ent_t             w_nxt [DEPTH];
    ent_t             w_in;
    ent_t             w_pick;
    logic [DEPTH-1:0] w_rdy;
    logic             w_any;
    logic [IW-1:0]    w_sel;
    logic [IW-1:0]    w_slot;
    logic             w_full;
    logic             w_iss;
    logic             w_acc;
    logic [CW-1:0]    w_cnt_nxt;

    // Capture a broadcast into any operand still waiting on that tag.
    function automatic ent_t snoop(
        input ent_t        e,
        input logic        cv,
        input logic [5:0]  ct,
        input logic [31:0] cd
    );
        ent_t o;
        o = e;
        if (cv && !e.a_v && e.a_t == ct) begin
            o.a_v = 1'b1;
            o.a_d = cd;
        end
        if (cv && !e.b_v && e.b_t == ct) begin
            o.b_v = 1'b1;
            o.b_d = cd;
        end
        return o;
    endfunction

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = r_q[i].v & r_q[i].a_v & r_q[i].b_v;
            if (w_rdy[i] && !w_any) begin
                w_any = 1'b1;
                w_sel = IW'(i);
            end
        end
        w_pick = w_any ? r_q[w_sel] : '0;
    end

    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_iss  = w_any & io_iq.issue_ready;
    assign w_acc  = io_iq.dispatch_en & ~w_full;
    assign w_slot = IW'(r_cnt - CW'(w_iss));

    assign w_cnt_nxt = r_cnt + CW'(w_acc) - CW'(w_iss);

    always_comb begin
        w_in      = '0;
        w_in.v    = 1'b1;
        w_in.a_v  = io_iq.rs1_data_valid;
        w_in.a_t  = io_iq.rs1_tag;
        w_in.a_d  = io_iq.rs1_data;
        w_in.b_v  = io_iq.rs2_data_valid;
        w_in.b_t  = io_iq.rs2_tag;
        w_in.b_d  = io_iq.rs2_data;
        w_in.rd   = io_iq.rd_tag;
        w_in.op   = io_iq.opcode;
        w_in.f3   = io_iq.func3;
        w_in.f7   = io_iq.func7;
        w_in      = snoop(w_in, io_iq.cdb_valid,
                          io_iq.cdb_tag, io_iq.cdb_data);
    end

    // Wakeup first, then compaction over the issued slot, then append.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = r_q[i];
            if (r_q[i].v) begin
                w_nxt[i] = snoop(r_q[i], io_iq.cdb_valid,
                                 io_iq.cdb_tag, io_iq.cdb_data);
            end
        end
        if (w_iss) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= w_sel) begin
                    w_nxt[i] = w_nxt[i+1];
                end
            end
            w_nxt[DEPTH-1] = '0;
        end
        if (w_acc) begin
            w_nxt[w_slot] = w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_cnt <= '0;
        end else if (io_iq.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nxt[i];
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign io_iq.issue_valid    = w_any;
    assign io_iq.issue_rs1_data = w_pick.a_d;
    assign io_iq.issue_rs2_data = w_pick.b_d;
    assign io_iq.issue_rd_tag   = w_pick.rd;
    assign io_iq.issue_opcode   = w_pick.op;
    assign io_iq.issue_func3    = w_pick.f3;
    assign io_iq.issue_func7    = w_pick.f7;
    assign io_iq.queue_full     = w_full;
    assign io_iq.entry_count    = r_cnt;
endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: scoreboard of expected issued packets plus
// direct checks of count, full, flush and reset behaviour.
module tb_int_issue_queue;
    logic clk;
    logic rst_n;

    int_issue_queue_if #(.DEPTH(4)) bus ();

    int_issue_queue #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_iq (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] rd, input logic [31:0] a,
                        input logic [31:0] b);
        sb.push_back('{rd: rd, a: a, b: b});
    endtask

    task automatic drive(input logic [5:0] rd,
                         input logic [31:0] a, input logic av,
                         input logic [5:0] at,
                         input logic [31:0] b, input logic bv,
                         input logic [5:0] bt);
        bus.dispatch_en    = 1'b1;
        bus.rd_tag         = rd;
        bus.rs1_data       = a;
        bus.rs1_data_valid = av;
        bus.rs1_tag        = at;
        bus.rs2_data       = b;
        bus.rs2_data_valid = bv;
        bus.rs2_tag        = bt;
        bus.opcode         = 7'h33;
        bus.func3          = rd[2:0];
        bus.func7          = {1'b0, rd};
    endtask

    task automatic disp(input logic [5:0] rd,
                        input logic [31:0] a, input logic av,
                        input logic [5:0] at,
                        input logic [31:0] b, input logic bv,
                        input logic [5:0] bt);
        drive(rd, a, av, at, b, bv, bt);
        tick();
        bus.dispatch_en = 1'b0;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk({"drain_", tag}, 32'(sb.size()), 32'd0);
    endtask

    // Every completed handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.issue_valid && bus.issue_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 32'(bus.issue_rd_tag), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("iss_rd", 32'(bus.issue_rd_tag), 32'(e.rd));
                chk("iss_rs1", bus.issue_rs1_data, e.a);
                chk("iss_rs2", bus.issue_rs2_data, e.b);
                chk("iss_op", 32'(bus.issue_opcode), 32'h33);
                chk("iss_f3", 32'(bus.issue_func3), 32'(e.rd[2:0]));
                chk("iss_f7", 32'(bus.issue_func7), 32'(e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.dispatch_en = 1'b0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rs1_data_valid = 1'b0;
        bus.rs2_data_valid = 1'b0;
        bus.rs1_tag = '0;
        bus.rs2_tag = '0;
        bus.rd_tag = '0;
        bus.opcode = '0;
        bus.func3 = '0;
        bus.func7 = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        bus.cdb_data = '0;
        bus.flush = 1'b0;
        bus.issue_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_cnt", 32'(bus.entry_count), 32'd0);
        chk("rst_full", 32'(bus.queue_full), 32'd0);
        chk("rst_rd", 32'(bus.issue_rd_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ready dispatch issues the next cycle.
        bus.issue_ready = 1'b1;
        push(6'd5, 32'h11, 32'h22);
        disp(6'd5, 32'h11, 1'b1, 6'd0, 32'h22, 1'b1, 6'd0);
        chk("t1_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_rd", 32'(bus.issue_rd_tag), 32'd5);
        chk("t1_cnt1", 32'(bus.entry_count), 32'd1);
        tick();
        chk("t1_cnt0", 32'(bus.entry_count), 32'd0);
        chk("t1_idle", 32'(bus.issue_valid), 32'd0);

        // Stored operand woken by a later broadcast.
        push(6'd6, 32'hDEADBEEF, 32'h33);
        disp(6'd6, 32'h0, 1'b0, 6'd12, 32'h33, 1'b1, 6'd0);
        chk("t2_wait0", 32'(bus.issue_valid), 32'd0);
        tick();
        chk("t2_wait1", 32'(bus.issue_valid), 32'd0);
        cdb(6'd12, 32'hDEADBEEF);
        tick();
        bus.cdb_valid = 1'b0;
        chk("t2_valid", 32'(bus.issue_valid), 32'd1);
        chk("t2_rs1", bus.issue_rs1_data, 32'hDEADBEEF);
        tick();

        // Broadcast in the dispatch cycle is captured by the new entry.
        push(6'd7, 32'h44, 32'hCAFE0007);
        cdb(6'd7, 32'hCAFE0007);
        disp(6'd7, 32'h44, 1'b1, 6'd0, 32'h0, 1'b0, 6'd7);
        bus.cdb_valid = 1'b0;
        chk("t3_valid", 32'(bus.issue_valid), 32'd1);
        chk("t3_rs2", bus.issue_rs2_data, 32'hCAFE0007);
        tick();
        chk("t3_cnt", 32'(bus.entry_count), 32'd0);

        // Fill, drop when full (also with a same-cycle issue), drain in order.
        bus.issue_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push(6'(k), 32'h100 + k, 32'h200 + k);
            disp(6'(k), 32'h100 + k, 1'b1, 6'd0, 32'h200 + k, 1'b1, 6'd0);
        end
        chk("t4_full", 32'(bus.queue_full), 32'd1);
        chk("t4_cnt4", 32'(bus.entry_count), 32'd4);
        disp(6'd9, 32'h9, 1'b1, 6'd0, 32'h9, 1'b1, 6'd0);
        chk("t4_drop", 32'(bus.entry_count), 32'd4);
        chk("t4_hold", 32'(bus.issue_rd_tag), 32'd1);
        bus.issue_ready = 1'b1;
        disp(6'd10, 32'hA, 1'b1, 6'd0, 32'hA, 1'b1, 6'd0);
        chk("t4_dropiss", 32'(bus.entry_count), 32'd3);
        chk("t4_notfull", 32'(bus.queue_full), 32'd0);
        drain("t4");
        chk("t4_cnt0", 32'(bus.entry_count), 32'd0);

        // Younger ready entry bypasses an older waiting one.
        bus.issue_ready = 1'b0;
        disp(6'd20, 32'h0, 1'b0, 6'd9, 32'h520, 1'b1, 6'd0);
        disp(6'd21, 32'h421, 1'b1, 6'd0, 32'h521, 1'b1, 6'd0);
        chk("t5_first", 32'(bus.issue_rd_tag), 32'd21);
        push(6'd21, 32'h421, 32'h521);
        push(6'd20, 32'h99, 32'h520);
        bus.issue_ready = 1'b1;
        tick();
        chk("t5_wait", 32'(bus.issue_valid), 32'd0);
        cdb(6'd9, 32'h99);
        tick();
        bus.cdb_valid = 1'b0;
        chk("t5_second", 32'(bus.issue_rd_tag), 32'd20);
        drain("t5");

        // Flush beats a same-cycle dispatch.
        bus.issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(6'(40 + k), 32'h1, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0);
        end
        chk("t6_cnt3", 32'(bus.entry_count), 32'd3);
        bus.flush = 1'b1;
        drive(6'd43, 32'h3, 1'b1, 6'd0, 32'h4, 1'b1, 6'd0);
        tick();
        bus.flush = 1'b0;
        bus.dispatch_en = 1'b0;
        chk("t6_cnt0", 32'(bus.entry_count), 32'd0);
        chk("t6_valid", 32'(bus.issue_valid), 32'd0);
        chk("t6_full", 32'(bus.queue_full), 32'd0);

        // Asynchronous reset mid-cycle, then normal operation.
        for (int k = 0; k < 3; k++) begin
            disp(6'(50 + k), 32'h5, 1'b1, 6'd0, 32'h6, 1'b1, 6'd0);
        end
        chk("t7_pre", 32'(bus.entry_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", 32'(bus.issue_valid), 32'd0);
        chk("t7_cnt", 32'(bus.entry_count), 32'd0);
        chk("t7_rd", 32'(bus.issue_rd_tag), 32'd0);
        chk("t7_rs1", bus.issue_rs1_data, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        bus.issue_ready = 1'b1;
        push(6'd60, 32'h600, 32'h601);
        disp(6'd60, 32'h600, 1'b1, 6'd0, 32'h601, 1'b1, 6'd0);
        chk("t7_post", 32'(bus.issue_rd_tag), 32'd60);
        drain("t7");
        chk("t7_end", 32'(bus.entry_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
